// File: rtl/alu_logic_pkg.sv
// Shared opcode definitions for the ALU logic-operation lane.
package alu_logic_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
   localparam logic [OP_W-1:0] OP_AND  = 3'd1;
   localparam logic [OP_W-1:0] OP_OR   = 3'd2;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_NAND = 3'd4;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
   localparam logic [OP_W-1:0] OP_NEG  = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise/negate datapath with result status flags.
module logic_unit_core
   import alu_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

   always_comb begin
      result = '0;
      case (op)
         OP_NOT:  result = ~a;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NAND: result = ~(a & b);
         OP_NOR:  result = ~(a | b);
         OP_XNOR: result = ~(a ^ b);
         OP_NEG:  result = ~a + WIDTH'(1);
         default: result = '0;
      endcase
      zero = (result == '0);
      neg  = result[WIDTH-1];
      // Negating the most-negative value wraps back onto itself.
      ovf  = (op == OP_NEG) && (a == MOST_NEG);
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core: S1 holds operands, S2 holds result+flags.
module logic_unit_pipe
   import alu_logic_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf
);

   logic             s1_valid_q, s1_valid_d;
   logic [OP_W-1:0]  s1_op_q,    s1_op_d;
   logic [WIDTH-1:0] s1_a_q,     s1_a_d;
   logic [WIDTH-1:0] s1_b_q,     s1_b_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q,  s2_data_d;
   logic             s2_zero_q,  s2_zero_d;
   logic             s2_neg_q,   s2_neg_d;
   logic             s2_ovf_q,   s2_ovf_d;

   logic             s2_adv;
   logic             s1_adv;
   logic             in_fire;

   logic [WIDTH-1:0] core_result;
   logic             core_zero;
   logic             core_neg;
   logic             core_ovf;

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op     (s1_op_q),
      .a      (s1_a_q),
      .b      (s1_b_q),
      .result (core_result),
      .zero   (core_zero),
      .neg    (core_neg),
      .ovf    (core_ovf)
   );

   // Handshake and next-state for both stages; in_ready is the only comb path (from out_ready).
   always_comb begin
      s2_adv     = !s2_valid_q || out_ready;
      s1_adv     = s1_valid_q && s2_adv;
      in_ready   = !s1_valid_q || s2_adv;
      in_fire    = in_valid && in_ready;

      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      s2_zero_d  = s2_zero_q;
      s2_neg_d   = s2_neg_q;
      s2_ovf_d   = s2_ovf_q;

      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_a_d     = in_a;
         s1_b_d     = in_b;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      // Bubbles clear the valid but leave the last result on the data lines.
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_adv) begin
         s2_data_d = core_result;
         s2_zero_d = core_zero;
         s2_neg_d  = core_neg;
         s2_ovf_d  = core_ovf;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         s2_zero_q  <= 1'b0;
         s2_neg_q   <= 1'b0;
         s2_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_op_q    <= s1_op_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         s2_zero_q  <= s2_zero_d;
         s2_neg_q   <= s2_neg_d;
         s2_ovf_q   <= s2_ovf_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_data  = s2_data_q;
   assign out_zero  = s2_zero_q;
   assign out_neg   = s2_neg_q;
   assign out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed + random bench for logic_unit_pipe at WIDTH=16 and WIDTH=8 with scoreboards.
module tb_logic_unit_pipe;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [2:0]  in_op16;
   logic [15:0] in_a16, in_b16, out_data16;
   logic        out_zero16, out_neg16, out_ovf16;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [2:0]  in_op8;
   logic [7:0]  in_a8, in_b8, out_data8;
   logic        out_zero8, out_neg8, out_ovf8;

   int errors = 0;
   int checks = 0;
   int n_out16 = 0;
   int n_out8 = 0;

   logic [18:0] sb16[$];
   logic [18:0] sb8[$];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid16), .in_ready(in_ready16), .in_op(in_op16),
      .in_a(in_a16), .in_b(in_b16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
      .out_zero(out_zero16), .out_neg(out_neg16), .out_ovf(out_ovf16)
   );

   logic_unit_pipe #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
      .in_a(in_a8), .in_b(in_b8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .out_zero(out_zero8), .out_neg(out_neg8), .out_ovf(out_ovf8)
   );

   // Reference: {ovf, neg, zero, result} with result masked to w bits.
   function automatic logic [18:0] model(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input int w);
      logic [15:0] m;
      logic [15:0] r;
      logic [15:0] mn;
      m  = 16'((32'd1 << w) - 32'd1);
      mn = 16'(32'd1 << (w - 1));
      case (op)
         3'd0: r = ~a;
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = a ^ b;
         3'd4: r = ~(a & b);
         3'd5: r = ~(a | b);
         3'd6: r = ~(a ^ b);
         default: r = 16'd0 - a;
      endcase
      r = r & m;
      return {(op == 3'd7) && (a == mn), r[w-1], (r == 16'd0), r};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive16(input logic v, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b);
      in_valid16 = v;
      in_op16    = op;
      in_a16     = a;
      in_b16     = b;
   endtask

   task automatic drive8(input logic v, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
      in_valid8 = v;
      in_op8    = op;
      in_a8     = a;
      in_b8     = b;
   endtask

   // Transfer monitors: push on input handshake, pop and compare on output handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (in_valid16 && in_ready16) sb16.push_back(model(in_op16, in_a16, in_b16, 16));
         if (out_valid16 && out_ready16) begin
            n_out16++;
            chk("sb16_has_entry", 32'(sb16.size() != 0), 32'd1);
            if (sb16.size() != 0)
               chk("sb16_out", 32'({out_ovf16, out_neg16, out_zero16, out_data16}),
                   32'(sb16.pop_front()));
         end
         if (in_valid8 && in_ready8) sb8.push_back(model(in_op8, {8'h0, in_a8}, {8'h0, in_b8}, 8));
         if (out_valid8 && out_ready8) begin
            n_out8++;
            chk("sb8_has_entry", 32'(sb8.size() != 0), 32'd1);
            if (sb8.size() != 0)
               chk("sb8_out", 32'({out_ovf8, out_neg8, out_zero8, 8'h00, out_data8}),
                   32'(sb8.pop_front()));
         end
      end
   end

   initial begin
      logic [15:0] strm[8];
      logic [18:0] negx[3];
      logic [15:0] nega[3];
      int          n_snap;
      strm = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'h0F10};
      nega = '{16'h0001, 16'h0000, 16'h8000};
      negx = '{{3'b010, 16'hFFFF}, {3'b001, 16'h0000}, {3'b110, 16'h8000}};

      rst_n = 1'b0;
      drive16(1'b0, 3'd0, 16'h0, 16'h0);
      drive8(1'b0, 3'd0, 8'h0, 8'h0);
      out_ready16 = 1'b1;
      out_ready8  = 1'b1;
      repeat (2) tick();
      chk("rst_valid16", 32'(out_valid16), 32'd0);
      chk("rst_out16", 32'({out_ovf16, out_neg16, out_zero16, out_data16}), 32'd0);
      chk("rst_out8", 32'({out_valid8, out_ovf8, out_neg8, out_zero8, out_data8}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready16", 32'(in_ready16), 32'd1);
      tick();

      // Single NOT with two-cycle latency
      drive16(1'b1, 3'd0, 16'h0168, 16'h0000);
      tick();
      drive16(1'b0, 3'd0, 16'h0, 16'h0);
      chk("not_lat_n1", 32'(out_valid16), 32'd0);
      tick();
      chk("not_lat_n2", 32'(out_valid16), 32'd1);
      chk("not_result", 32'({out_ovf16, out_neg16, out_zero16, out_data16}), {13'd0, 3'b010, 16'hFE97});
      repeat (2) tick();

      // NEG sweep, back to back
      for (int i = 0; i < 4; i++) begin
         if (i < 3) drive16(1'b1, 3'd7, nega[i], 16'h0);
         else       drive16(1'b0, 3'd0, 16'h0, 16'h0);
         tick();
         if (i >= 1)
            chk("neg_sweep", 32'({out_ovf16, out_neg16, out_zero16, out_data16}), 32'(negx[i-1]));
      end
      tick();
      chk("neg_sweep_last", 32'({out_ovf16, out_neg16, out_zero16, out_data16}), 32'(negx[2]));
      repeat (2) tick();

      // Stream of all eight opcodes, one result per cycle
      n_snap = n_out16;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) drive16(1'b1, 3'(i), 16'hF0F0, 16'hFF00);
         else       drive16(1'b0, 3'd0, 16'h0, 16'h0);
         tick();
         if (i >= 1) begin
            chk("stream_valid", 32'(out_valid16), 32'd1);
            chk("stream_data", 32'(out_data16), 32'(strm[i-1]));
         end
      end
      tick();
      chk("stream_count", 32'(n_out16 - n_snap), 32'd8);
      repeat (2) tick();

      // Backpressure: in_ready falls after two accepts, output held stable
      n_snap = n_out16;
      out_ready16 = 1'b0;
      drive16(1'b1, 3'd3, 16'h1234, 16'h00FF);
      tick();
      drive16(1'b1, 3'd7, 16'h8000, 16'h0);
      tick();
      drive16(1'b1, 3'd4, 16'hAAAA, 16'h5555);
      chk("bp_in_ready_low", 32'(in_ready16), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold_valid", 32'(out_valid16), 32'd1);
         chk("bp_hold_data", 32'(out_data16), 32'h12CB);
         chk("bp_in_ready_held", 32'(in_ready16), 32'd0);
      end
      out_ready16 = 1'b1;
      #1;
      chk("bp_in_ready_release", 32'(in_ready16), 32'd1);
      tick();
      drive16(1'b0, 3'd0, 16'h0, 16'h0);
      repeat (4) tick();
      chk("bp_count", 32'(n_out16 - n_snap), 32'd3);
      chk("bp_sb_empty", 32'(sb16.size()), 32'd0);

      // Asynchronous reset with both stages full
      out_ready16 = 1'b0;
      drive16(1'b1, 3'd1, 16'hFFFF, 16'h0F0F);
      tick();
      drive16(1'b1, 3'd2, 16'h0001, 16'h0002);
      tick();
      drive16(1'b0, 3'd0, 16'h0, 16'h0);
      chk("mid_full_in_ready", 32'(in_ready16), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", 32'({out_valid16, out_ovf16, out_neg16, out_zero16, out_data16}), 32'd0);
      sb16.delete();
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      chk("mid_in_ready", 32'(in_ready16), 32'd1);
      out_ready16 = 1'b1;
      n_snap = n_out16;
      repeat (4) tick();
      chk("mid_no_stale", 32'(n_out16 - n_snap), 32'd0);
      chk("mid_valid_low", 32'(out_valid16), 32'd0);

      // WIDTH=8 instance
      drive8(1'b1, 3'd5, 8'h00, 8'h00);
      tick();
      drive8(1'b1, 3'd7, 8'h80, 8'h00);
      tick();
      drive8(1'b0, 3'd0, 8'h00, 8'h00);
      chk("w8_nor", 32'({out_valid8, out_ovf8, out_neg8, out_zero8, out_data8}), {20'd0, 4'b1010, 8'hFF});
      tick();
      chk("w8_neg", 32'({out_valid8, out_ovf8, out_neg8, out_zero8, out_data8}), {20'd0, 4'b1110, 8'h80});
      repeat (2) tick();

      // Random traffic with random backpressure, then bounded drain
      for (int i = 0; i < 200; i++) begin
         drive16(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
         out_ready16 = ($urandom_range(0, 3) != 0);
         tick();
      end
      drive16(1'b0, 3'd0, 16'h0, 16'h0);
      out_ready16 = 1'b1;
      for (int i = 0; i < 10 && sb16.size() != 0; i++) tick();
      chk("rand_drained", 32'(sb16.size()), 32'd0);
      chk("w8_drained", 32'(sb8.size()), 32'd0);
      chk("w8_count", 32'(n_out8), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise/negate unit. Successor to the fixed 16-bit combinational inverter; now generalised in width and operation mode.
- Accepts operand pairs plus an opcode over a valid/ready handshake and returns a registered result with status flags.
- Sits in the ALU datapath as the logic-operation lane, beside the adder lanes.

Parameters:
- WIDTH, 16, operand/result width in bits (legal ≥ 2).

Ports:
- clk        input   1      single clock, rising-edge.
- rst_n      input   1      asynchronous active-low reset.
- in_valid   input   1      operand/opcode presented.
- in_ready   output  1      unit can accept this cycle.
- in_op      input   3      opcode (see Behaviour).
- in_a       input   WIDTH  operand A.
- in_b       input   WIDTH  operand B (ignored by NOT/NEG).
- out_valid  output  1      result present.
- out_ready  input   1      consumer accepts result.
- out_data   output  WIDTH  result.
- out_zero   output  1      out_data == 0.
- out_neg    output  1      out_data[WIDTH-1].
- out_ovf    output  1      NEG of most-negative value (A == 1 followed by WIDTH-1 zeros); 0 for all other ops.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low (rst_n).
  - On reset, all pipeline valids are 0, and out_valid, out_data, out_zero, out_neg and out_ovf are all 0.
  - in_ready is 1 in the first cycle after reset release.
- Opcodes:
  - 0 NOT: ~A
  - 1 AND: A&B
  - 2 OR: A|B
  - 3 XOR: A^B
  - 4 NAND: ~(A&B)
  - 5 NOR: ~(A|B)
  - 6 XNOR: ~(A^B)
  - 7 NEG: ~A+1, modulo 2^WIDTH.
- Pipeline:
  - Two stages.
  - S1 registers {op, A, B}.
  - S2 registers the computed result and flags. out_* are driven directly from S2 registers.
  - Latency: accepted in cycle N → out_valid in cycle N+2 when there is no backpressure.
  - Throughput: 1 per cycle.
- Handshake:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready
  - s1_adv = s1_valid & s2_adv
  - in_ready = !s1_valid | s2_adv. It is combinational from out_ready; no other combinational in→out path exists.
- Stall:
  - When out_valid=1 and out_ready=0, out_data and flags hold stable.
  - S1 holds if it is full. in_ready drops once both stages are full.
  - No data is lost or duplicated.
- Simultaneous events:
  - S2 is emptied and refilled in the same cycle when out_ready=1 and S1 is valid.
  - S1 is emptied and refilled in the same cycle when the input transfer and s1_adv coincide.
- Bubbles:
  - When s2_adv=1 and S1 is empty, s2_valid becomes 0.
  - out_data keeps its last value; its value is don't-care while out_valid=0.
- Reset mid-operation: in-flight transactions are discarded. No output transfer appears after reset.
- Undefined opcodes: none; all 8 codes are legal.
- Flags are computed on the final result in the same stage as the result. out_ovf uses only A and op.

Decomposition:
- Package alu_logic_pkg:
  - opcode constants: OP_NOT=3'd0 … OP_NEG=3'd7
  - OP_W=3
- Sub-module logic_unit_core (purely combinational):
  - inputs: op, a, b
  - outputs: result, zero, neg, ovf
  - Parametrised by WIDTH and instantiated once between S1 and S2.
  - Its internal NOT path generalises the existing 16-bit inverter.

Test Plan:
- WIDTH=16, single NOT, A=16'h0168 (360), out_ready=1 → cycle+2: out_data=16'hFE97, out_neg=1, out_zero=0, out_ovf=0.
- NEG sweep:
  - A=16'h0001 → 16'hFFFF, neg=1.
  - A=16'h0000 → 16'h0000, zero=1.
  - A=16'h8000 → 16'h8000, ovf=1, neg=1.
- Back-to-back stream of 8 ops (codes 0..7, A=16'hF0F0, B=16'hFF00), out_ready=1:
  - one result per cycle, in order.
  - Results: 0F0F, F000, FFF0, 0FF0, 0FFF, 000F, F00F, 0F10.
- Backpressure:
  - Hold out_ready=0 while streaming → in_ready falls after 2 accepts and out_data stays constant.
  - Release → remaining results are delivered in order, none dropped or duplicated; scoreboard matches.
- Reset mid-flight: assert rst_n=0 asynchronously with both stages full → out_valid=0 and all flags 0 immediately; in_ready=1 after release; no stale output.
- WIDTH=8 instance:
  - NOR A=8'h00, B=8'h00 → 8'hFF, neg=1.
  - NEG A=8'h80 → 8'h80, ovf=1.
